// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, lane masks.
package lsu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [WORD_W-1:0] HALF_MASK = 32'h0000_FFFF;

  typedef enum logic [OP_W-1:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_ERR    = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_e;

  // True for every op that returns data from memory
  function automatic logic is_load(input lsu_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension, store merge, alignment check.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_op_e           op,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] mem_word,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged_word,
  output logic              misaligned
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign byte_sh   = {addr_lo, 3'b000};
  assign half_sh   = {addr_lo[1], 4'b0000};
  assign lane_byte = 8'(mem_word >> byte_sh);
  assign lane_half = 16'(mem_word >> half_sh);

  // Extract the addressed lane and sign/zero extend it
  always_comb begin
    load_data = '0;
    case (op)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'h0, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'h0, lane_half};
      OP_LW:   load_data = mem_word;
      default: load_data = '0;
    endcase
  end

  // Overlay the new byte/halfword onto the old word, other lanes untouched
  always_comb begin
    merged_word = mem_word;
    case (op)
      OP_SB:   merged_word = (mem_word & ~(BYTE_MASK << byte_sh)) |
                             ((store_data & BYTE_MASK) << byte_sh);
      OP_SH:   merged_word = (mem_word & ~(HALF_MASK << half_sh)) |
                             ((store_data & HALF_MASK) << half_sh);
      OP_SW:   merged_word = store_data;
      default: merged_word = mem_word;
    endcase
  end

  // Halfwords need even addresses, words need 4-byte alignment
  always_comb begin
    misaligned = 1'b1;
    case (op)
      OP_LB, OP_LBU, OP_SB: misaligned = 1'b0;
      OP_LH, OP_LHU, OP_SH: misaligned = addr_lo[0];
      OP_LW, OP_SW:         misaligned = |addr_lo;
      default:              misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_memread,
  output logic              mem_memwrite
);

  lsu_state_e  state;
  lsu_op_e     op_in;
  lsu_op_e     op_q;
  logic [1:0]  addr_lo_q;
  logic [DATA_W-1:0] wdata_q;

  lsu_op_e     sel_op;
  logic [1:0]  sel_addr_lo;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;
  logic        misaligned;

  assign op_in     = lsu_op_e'(req_op);
  assign req_ready = reset_n && (state == S_IDLE);

  // Alignment is judged on the live request in IDLE, lane work on the latched one
  assign sel_op      = (state == S_IDLE) ? op_in : op_q;
  assign sel_addr_lo = (state == S_IDLE) ? req_addr[1:0] : addr_lo_q;

  lsu_lane_align u_lane_align (
    .op          (sel_op),
    .addr_lo     (sel_addr_lo),
    .mem_word    (mem_read_data),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misaligned  (misaligned)
  );

  // Request sequencing with registered memory and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      op_q           <= OP_LB;
      addr_lo_q      <= '0;
      wdata_q        <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_add        <= '0;
      mem_write_data <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else begin
      resp_valid   <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= op_in;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_add   <= {2'b00, req_addr[ADDR_W-1:2]};
            if (misaligned) begin
              state <= S_ERR;
            end else if (is_load(op_in)) begin
              state       <= S_RD;
              mem_memread <= 1'b1;
            end else if (op_in == OP_SW) begin
              state          <= S_WR;
              mem_memwrite   <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state       <= S_RMW_RD;
              mem_memread <= 1'b1;
            end
          end
        end
        S_RD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RMW_RD: begin
          mem_write_data <= merged_word;
          mem_memwrite   <= 1'b1;
          state          <= S_WR;
        end
        S_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_ERR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-array memory and reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_add;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_memread;
  logic        mem_memwrite;

  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'd0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_add        (mem_add),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory with combinational read
  assign mem_read_data = (mem_add < 32'd16) ? mem[mem_add[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_memwrite) begin
      if (mem_add < 32'd16) mem[mem_add[3:0]] <= mem_write_data;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 4'(idx); pre_data = val;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference model: architectural effect of one request on ref_mem
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    longint unsigned word, lane, off, w;
    longint v;
    w = longint'(addr) / 4;
    off = longint'(addr) % 4;
    rdata = 32'h0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) err = (off % 2) != 0;
    else if (op == OP_LW || op == OP_SW) err = (off != 0);
    else err = 1'b0;
    lat = (!err && (op == OP_SB || op == OP_SH)) ? 3 : 2;
    if (!err) begin
      word = longint'(ref_mem[w]);
      case (op)
        OP_LB:  begin v = longint'((word >> (8 * off)) % 256); if (v >= 128) v = v - 256; rdata = 32'(v); end
        OP_LBU: rdata = 32'((word >> (8 * off)) % 256);
        OP_LH:  begin v = longint'((word >> (8 * off)) % 65536); if (v >= 32768) v = v - 65536; rdata = 32'(v); end
        OP_LHU: rdata = 32'((word >> (8 * off)) % 65536);
        OP_LW:  rdata = 32'(word);
        OP_SB: begin
          lane = (word >> (8 * off)) % 256;
          ref_mem[w] = 32'(word - (lane << (8 * off)) + ((longint'(wdata) % 256) << (8 * off)));
        end
        OP_SH: begin
          lane = (word >> (8 * off)) % 65536;
          ref_mem[w] = 32'(word - (lane << (8 * off)) + ((longint'(wdata) % 65536) << (8 * off)));
        end
        default: ref_mem[w] = wdata;
      endcase
    end
  endtask

  // Drive one request in the next cycle and collect what the DUT did
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic rdy, output logic saw_rd, output logic saw_wr,
                       output logic saw_both, output logic [31:0] add_seen);
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    add_seen = mem_add;
    lat = 1; saw_rd = 1'b0; saw_wr = 1'b0; saw_both = 1'b0;
    while (!resp_valid && lat < 8) begin
      saw_rd = saw_rd | mem_memread;
      saw_wr = saw_wr | mem_memwrite;
      saw_both = saw_both | (mem_memread & mem_memwrite);
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    @(negedge clk);
    outs = {31'h0, req_ready} | {31'h0, resp_valid} | resp_rdata | {31'h0, resp_err} |
           mem_add | mem_write_data | {31'h0, mem_memread} | {31'h0, mem_memwrite};
    total++;
    if (outs !== 32'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    reset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_load_extend();
    logic [31:0] rd, a, er; logic e, ee, r, sr, sw, sb; int lat, el;
    poke(1, 32'h0000_00A5);
    model(OP_LB, 32'h4, 32'h0, er, ee, el);
    issue(OP_LB, 32'h4, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (rd !== 32'hFFFF_FFA5) begin bad++; $display("FAIL lb_data: got %h want ffffffa5", rd); end
    total++; if (lat != 2) begin bad++; $display("FAIL lb_latency: got %0d want 2", lat); end
    total++; if (a !== 32'h1) begin bad++; $display("FAIL lb_mem_add: got %h want 1", a); end
    total++; if (sr !== 1'b1 || sw !== 1'b0) begin bad++; $display("FAIL lb_enables: got rd=%b wr=%b want rd=1 wr=0", sr, sw); end
    model(OP_LBU, 32'h4, 32'h0, er, ee, el);
    issue(OP_LBU, 32'h4, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL lbu_data: got %h want 000000a5", rd); end
  endtask

  task automatic test_sub_word_store();
    logic [31:0] rd, a, er; logic e, ee, r, sr, sw, sb; int lat, el;
    model(OP_SB, 32'h5, 32'h1234_567F, er, ee, el);
    issue(OP_SB, 32'h5, 32'h1234_567F, rd, e, lat, r, sr, sw, sb, a);
    total++; if (mem[1] !== 32'h0000_7FA5) begin bad++; $display("FAIL sb_word: got %h want 00007fa5", mem[1]); end
    total++; if (lat != 3) begin bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
    total++; if (sr !== 1'b1 || sw !== 1'b1 || sb !== 1'b0) begin bad++; $display("FAIL sb_rmw: got rd=%b wr=%b both=%b want 1 1 0", sr, sw, sb); end
    total++; if (rd !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL sb_resp: got rdata=%h err=%b want 0 0", rd, e); end
    poke(2, 32'h0000_0001);
    model(OP_SH, 32'hA, 32'h0000_BEEF, er, ee, el);
    issue(OP_SH, 32'hA, 32'h0000_BEEF, rd, e, lat, r, sr, sw, sb, a);
    total++; if (mem[2] !== 32'hBEEF_0001) begin bad++; $display("FAIL sh_word: got %h want beef0001", mem[2]); end
    model(OP_LH, 32'hA, 32'h0, er, ee, el);
    issue(OP_LH, 32'hA, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (rd !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh_data: got %h want ffffbeef", rd); end
    model(OP_LHU, 32'hA, 32'h0, er, ee, el);
    issue(OP_LHU, 32'hA, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (rd !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_data: got %h want 0000beef", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, a; logic e, r, sr, sw, sb; int lat;
    issue(OP_LW, 32'h6, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lw_mis_resp: got err=%b rdata=%h want 1 0", e, rd); end
    total++; if (sr !== 1'b0 || sw !== 1'b0) begin bad++; $display("FAIL lw_mis_mem: got rd=%b wr=%b want 0 0", sr, sw); end
    total++; if (lat != 2) begin bad++; $display("FAIL lw_mis_latency: got %0d want 2", lat); end
    issue(OP_LH, 32'h3, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL lh_mis_err: got %b want 1", e); end
    issue(OP_LB, 32'h3, 32'h0, rd, e, lat, r, sr, sw, sb, a);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL lb_odd_err: got %b want 0", e); end
  endtask

  task automatic test_reset_mid_write();
    logic saw_resp;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (mem_memwrite !== 1'b1) begin bad++; $display("FAIL sw_in_wr: got memwrite=%b want 1", mem_memwrite); end
    reset_n = 1'b0;
    #1;
    total++; if (mem_memwrite !== 1'b0) begin bad++; $display("FAIL abort_memwrite: got %b want 0", mem_memwrite); end
    saw_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_resp = saw_resp | resp_valid; end
    reset_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_resp = saw_resp | resp_valid; end
    total++; if (saw_resp !== 1'b0) begin bad++; $display("FAIL abort_no_resp: got %b want 0", saw_resp); end
    total++; if (mem[2] !== ref_mem[2]) begin bad++; $display("FAIL abort_word: got %h want %h", mem[2], ref_mem[2]); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] er; logic ee; int el;
    model(OP_LW, 32'h0, 32'h0, er, ee, el);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    req_op = OP_SW; req_addr = 32'h4; req_wdata = $urandom;
    total++; if (req_ready !== 1'b0 || mem_memwrite !== 1'b0) begin bad++; $display("FAIL busy_c1: got ready=%b wr=%b want 0 0", req_ready, mem_memwrite); end
    @(negedge clk);
    req_op = OP_SB; req_addr = 32'h5;
    total++; if (resp_valid !== 1'b1 || resp_rdata !== er) begin bad++; $display("FAIL busy_resp: got v=%b data=%h want 1 %h", resp_valid, resp_rdata, er); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready_resp: got %b want 0", req_ready); end
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL busy_after: got ready=%b v=%b want 1 0", req_ready, resp_valid); end
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL busy_mem%0d: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, er, addr, wd; logic e, ee, r, sr, sw, sb; int lat, el; logic [2:0] op;
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
      wd = $urandom;
      model(op, addr, wd, er, ee, el);
      issue(op, addr, wd, rd, e, lat, r, sr, sw, sb, a);
      total++; if (r !== 1'b1) begin bad++; $display("FAIL rnd_ready #%0d: got %b want 1", n, r); end
      total++; if (e !== ee || rd !== er) begin bad++; $display("FAIL rnd_resp #%0d op=%0d addr=%h: got err=%b data=%h want err=%b data=%h", n, op, addr, e, rd, ee, er); end
      total++; if (lat != el) begin bad++; $display("FAIL rnd_latency #%0d op=%0d: got %0d want %0d", n, op, lat, el); end
      total++; if (sb !== 1'b0) begin bad++; $display("FAIL rnd_exclusive #%0d: got both=%b want 0", n, sb); end
      if (ee) begin
        total++; if (sr !== 1'b0 || sw !== 1'b0) begin bad++; $display("FAIL rnd_err_mem #%0d: got rd=%b wr=%b want 0 0", n, sr, sw); end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      total++; if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL rnd_mem%0d: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_extend();
    test_sub_word_store();
    test_misaligned();
    test_reset_mid_write();
    test_busy_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the datapath's ALU and data memory stage and the word-addressed data memory. It accepts one byte, halfword or word request at a time over a valid/ready handshake and handles all memory-side work. Loads are lane-extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence because the memory only writes whole words. Misaligned requests are rejected with an error response and never touch memory.

## Interface
- `ADDR_W`, 32: byte address width of requests.
- `DATA_W`, 32: data width. Fixed at 32; other values are unsupported.
- `clk` input 1: sole clock. Everything samples on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept. High only in IDLE.
- `req_op` input 3: operation code (`LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW`).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data. Sub-word stores use its low byte or low halfword.
- `resp_valid` output 1: one-cycle completion pulse. No backpressure.
- `resp_rdata` output 32: load result. Zero for stores and errors.
- `resp_err` output 1: misaligned request. Valid when `resp_valid` is high.
- `mem_add` output 32: word index to data memory, equal to `{2'b0, addr[31:2]}`.
- `mem_write_data` output 32: word written to memory.
- `mem_read_data` input 32: combinational read data from memory, same cycle as `mem_memread`.
- `mem_memread` output 1: memory read enable.
- `mem_memwrite` output 1: memory write enable. Memory writes on the next `clk` edge.

## Operation
- **Byte lanes:** little-endian. `addr[1:0]=0` selects bits 7:0; `addr[1]=0` selects halfword bits 15:0.
- **Alignment:** a halfword op with `addr[0]=1` is misaligned. A word op with `addr[1:0]≠0` is misaligned. Byte ops are always aligned.
- **States:**
  - IDLE: `req_ready=1`. On `req_valid` the unit latches op, address and data.
    - Misaligned request → ERR.
    - Load → RD.
    - `SW` → WR.
    - `SB` or `SH` → RMW_RD.
  - RD: `mem_memread=1`; latch the extracted and extended value → RESP.
  - RMW_RD: `mem_memread=1`; latch `mem_read_data` merged with the new byte or halfword in the addressed lane, other lanes untouched → WR.
  - WR: `mem_memwrite=1`, `mem_write_data` = latched word (`req_wdata` for `SW`, merged word for `SB`/`SH`) → RESP.
  - ERR: no memory enables → RESP with `resp_err=1`.
  - RESP: `resp_valid=1` for exactly one cycle → IDLE.
- **Extension:**
  - `LB` and `LH` sign-extend from bit 7 or bit 15.
  - `LBU` and `LHU` zero-extend.
- **Illegal codes:** an undefined `req_op` is treated as misaligned (error response).
- **Request signals outside IDLE:** ignored. Requests are never queued.
- **Read/write exclusivity:** `mem_memread` and `mem_memwrite` are never high in the same cycle.

## Timing
- **Reset values:** while `reset_n=0`, all outputs are 0, including `req_ready`, `mem_memwrite` and `mem_memread`. State is IDLE. `req_ready` rises combinationally in the first post-reset IDLE cycle.
- **Latency from the accepting edge to `resp_valid` high:**
  - Loads and `SW`: 2 cycles.
  - `SB` and `SH`: 3 cycles.
  - Error: 2 cycles.
- **Throughput:** next accept at the earliest 1 cycle after the RESP cycle, so load/`SW` issue every 3 cycles and sub-word stores every 4.
- **Reset mid-operation:** asserting `reset_n` low in any state aborts immediately.
  - `mem_memwrite` drops asynchronously, so the in-flight write does not occur if reset precedes the write edge.
  - No response is produced for the aborted request.
- **Output stability:** `resp_rdata` and `resp_err` are registered and hold their values until the next RESP.

## Structure
- **Package `lsu_pkg`:** `req_op` encodings, state enum, lane-select constants.
- **Sub-module `lsu_lane_align`:** combinational. Inputs: op, `addr[1:0]`, memory word, store data. Outputs: extended load value, merged store word, misaligned flag. The FSM is in the top module.

## Test plan
- Memory word 1 = `0x000000A5`:
  - `LB` addr `0x4` → `resp_rdata=0xFFFFFFA5`, 2-cycle latency, `mem_add=1`.
  - `LBU` addr `0x4` → `resp_rdata=0x000000A5`.
- `SB` `req_wdata=0x1234567F`, addr `0x5`, word 1 = `0xA5` → RMW: 1 read cycle then 1 write cycle. Word 1 becomes `0x00007FA5`; `resp_valid` 3 cycles after accept.
- `SH` `0xBEEF` to addr `0xA` then `LH` addr `0xA` → `0xFFFFBEEF`; `LHU` → `0x0000BEEF`; low half of word 2 unchanged (`0x0001`).
- `LW` addr `0x6` → `resp_err=1`, `resp_rdata=0`, `mem_memread` and `mem_memwrite` never asserted. `LH` addr `0x3` → error. `LB` addr `0x3` → no error.
- `reset_n` pulsed low during the WR state of `SW` `0xDEADBEEF` to addr `0x8` → `mem_memwrite` drops at once, word 2 unchanged, no `resp_valid`, `req_ready=1` after release.
- `req_valid` held high with changing ops during a busy load → only the first is accepted; `req_ready` stays low until the cycle after RESP.
